// File: rtl/event_debounce.sv
// Debounces an asynchronous event line and emits one strobe per accepted rising edge.
// Rising edges that arrive while pulses are disabled or inside the holdoff window are counted as drops.
//
// state     | meaning
// LOW       | debounced level 0, waiting for s2=1
// RISE_WAIT | s2 high, counting toward STABLE_CYCLES
// HIGH      | debounced level 1, waiting for s2=0
// FALL_WAIT | s2 low, counting toward STABLE_CYCLES
module event_debounce #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned HOLDOFF_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_raw,
  input  logic       io_en,
  output logic       io_pulse,
  output logic       io_level,
  output logic       io_drop,
  output logic [7:0] io_drop_cnt
);

  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLDOFF_CYCLES);
  localparam bit         SINGLE      = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_t;

  state_t     state_q;
  logic       s1_q, s2_q;
  logic [7:0] cnt_q;
  logic [7:0] hold_q;
  logic       pulse_q, drop_q, level_q;
  logic [7:0] drop_cnt_q;

  logic rise_evt;
  logic accept;

  // A debounced rising edge completes on this clock edge.
  assign rise_evt = s2_q && ((state_q == LOW && SINGLE) ||
                             (state_q == RISE_WAIT && cnt_q == STABLE_LAST));
  assign accept   = rise_evt && io_en && (hold_q == 8'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= LOW;
      cnt_q      <= 8'd0;
      hold_q     <= 8'd0;
      pulse_q    <= 1'b0;
      drop_q     <= 1'b0;
      level_q    <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      s1_q    <= io_raw;
      s2_q    <= s1_q;
      pulse_q <= accept;
      drop_q  <= rise_evt && !accept;

      if (accept)
        hold_q <= HOLD_LOAD;
      else if (hold_q != 8'd0)
        hold_q <= hold_q - 8'd1;

      if (rise_evt && !accept && drop_cnt_q != 8'hFF)
        drop_cnt_q <= drop_cnt_q + 8'd1;

      case (state_q)
        LOW: begin
          if (s2_q) begin
            if (SINGLE) begin
              state_q <= HIGH;
              cnt_q   <= 8'd0;
              level_q <= 1'b1;
            end else begin
              state_q <= RISE_WAIT;
              cnt_q   <= 8'd1;
            end
          end
        end
        RISE_WAIT: begin
          if (!s2_q) begin
            state_q <= LOW;
            cnt_q   <= 8'd0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= HIGH;
            cnt_q   <= 8'd0;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HIGH: begin
          if (!s2_q) begin
            if (SINGLE) begin
              state_q <= LOW;
              cnt_q   <= 8'd0;
              level_q <= 1'b0;
            end else begin
              state_q <= FALL_WAIT;
              cnt_q   <= 8'd1;
            end
          end
        end
        FALL_WAIT: begin
          // A glitch back high abandons the fall silently.
          if (s2_q) begin
            state_q <= HIGH;
            cnt_q   <= 8'd0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= LOW;
            cnt_q   <= 8'd0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= 8'd0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign io_pulse    = pulse_q;
  assign io_drop     = drop_q;
  assign io_level    = level_q;
  assign io_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_event_debounce.sv
// Bench for event_debounce: directed scenarios plus randomized traffic against a
// reference model built from consecutive-sample counting and pulse timestamps.
module tb_event_debounce;
  localparam int STABLE = 4;
  localparam int HOLD   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       io_raw = 1'b0;
  logic       io_en = 1'b0;
  logic       io_pulse, io_level, io_drop;
  logic [7:0] io_drop_cnt;

  always #5 clk = ~clk;

  event_debounce #(.STABLE_CYCLES(STABLE), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .io_raw(io_raw), .io_en(io_en),
    .io_pulse(io_pulse), .io_level(io_level), .io_drop(io_drop), .io_drop_cnt(io_drop_cnt)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  // Reference model: raw samples delayed two edges, level flips after STABLE
  // consecutive disagreeing samples, pulses spaced by more than HOLD edges.
  bit m_sync_old, m_sync_new;
  bit m_level;
  int m_run;
  bit m_has_last;
  int m_last;
  bit m_pulse, m_drop;
  int m_cnt;

  task automatic tick();
    bit s2, raw_s, en_s, rst_s;
    @(posedge clk);
    raw_s = io_raw;
    en_s  = io_en;
    rst_s = reset;
    if (!rst_s) begin
      m_sync_old = 0; m_sync_new = 0; m_level = 0; m_run = 0;
      m_has_last = 0; m_pulse = 0; m_drop = 0; m_cnt = 0;
    end else begin
      s2 = m_sync_old;
      m_sync_old = m_sync_new;
      m_sync_new = raw_s;
      m_pulse = 0;
      m_drop  = 0;
      if (s2 != m_level) m_run++;
      else m_run = 0;
      if (m_run == STABLE) begin
        m_level = s2;
        m_run   = 0;
        if (s2) begin
          if (en_s && (!m_has_last || (t - m_last) > HOLD)) begin
            m_pulse = 1; m_last = t; m_has_last = 1;
          end else begin
            m_drop = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end
    end
    t++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; io_raw = 1'b0; io_en = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({io_pulse, io_level, io_drop, io_drop_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got p=%b l=%b d=%b cnt=%0d, expected all 0",
               io_pulse, io_level, io_drop, io_drop_cnt);
    end
  endtask

  task automatic test_clean_edge();
    do_reset();
    repeat (3) tick();
    io_raw = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (io_pulse !== (i == 5)) begin
        errors++;
        $display("FAIL clean_pulse edge k+%0d: got %b expected %b", i, io_pulse, (i == 5));
      end
      checks++;
      if (io_level !== (i >= 5)) begin
        errors++;
        $display("FAIL clean_level edge k+%0d: got %b expected %b", i, io_level, (i >= 5));
      end
    end
    io_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_bounce();
    do_reset();
    repeat (3) tick();
    for (int i = 0; i < 13; i++) begin
      io_raw = (i != 3);
      tick();
      checks++;
      if (io_pulse !== (i == 9)) begin
        errors++;
        $display("FAIL bounce_pulse edge %0d: got %b expected %b", i, io_pulse, (i == 9));
      end
    end
  endtask

  task automatic test_holdoff();
    do_reset();
    repeat (3) tick();
    for (int i = 0; i < 30; i++) begin
      io_raw = (i < 5) || (i >= 10 && i < 15) || (i >= 20);
      tick();
      checks++;
      if (io_pulse !== (i == 5 || i == 25)) begin
        errors++;
        $display("FAIL holdoff_pulse edge %0d: got %b expected %b", i, io_pulse, (i == 5 || i == 25));
      end
      checks++;
      if (io_drop !== (i == 15)) begin
        errors++;
        $display("FAIL holdoff_drop edge %0d: got %b expected %b", i, io_drop, (i == 15));
      end
    end
    checks++;
    if (io_drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL holdoff_drop_cnt: got %0d expected 1", io_drop_cnt);
    end
  endtask

  task automatic test_disable();
    int strobes = 0;
    int pulses = 0;
    do_reset();
    io_en = 1'b0;
    for (int e = 0; e < 3; e++) begin
      for (int i = 0; i < 12; i++) begin
        io_raw = (i < 6);
        tick();
        if (io_pulse) pulses++;
        if (io_drop) strobes++;
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL disable_pulses: got %0d expected 0", pulses);
    end
    checks++;
    if (strobes !== 3) begin
      errors++;
      $display("FAIL disable_drop_strobes: got %0d expected 3", strobes);
    end
    checks++;
    if (io_drop_cnt !== 8'd3) begin
      errors++;
      $display("FAIL disable_drop_cnt: got %0d expected 3", io_drop_cnt);
    end
    // Drops never loaded hold, so an enabled edge right away must pulse.
    io_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      io_raw = 1'b1;
      tick();
      checks++;
      if (io_pulse !== (i == 5)) begin
        errors++;
        $display("FAIL disable_then_enable_pulse edge %0d: got %b expected %b", i, io_pulse, (i == 5));
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    io_en = 1'b0;
    for (int e = 0; e < 260; e++) begin
      for (int i = 0; i < 10; i++) begin
        io_raw = (i < 5);
        tick();
      end
      if (e >= 250) begin
        checks++;
        if (io_drop_cnt !== 8'((e + 1 > 255) ? 255 : e + 1)) begin
          errors++;
          $display("FAIL saturation_cnt after edge %0d: got %0d expected %0d",
                   e + 1, io_drop_cnt, (e + 1 > 255) ? 255 : e + 1);
        end
      end
    end
    io_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) tick();
    io_raw = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({io_pulse, io_level, io_drop, io_drop_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got p=%b l=%b d=%b cnt=%0d, expected all 0",
               io_pulse, io_level, io_drop, io_drop_cnt);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (io_pulse !== (i == 5)) begin
        errors++;
        $display("FAIL reset_mid_pulse edge r+%0d: got %b expected %b", i, io_pulse, (i == 5));
      end
    end
  endtask

  task automatic test_random();
    int run_left = 0;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (run_left == 0) begin
        io_raw   = $urandom_range(0, 1);
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      io_en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (io_pulse !== m_pulse) begin
        errors++;
        $display("FAIL rand_pulse t=%0d: got %b expected %b", t, io_pulse, m_pulse);
      end
      checks++;
      if (io_drop !== m_drop) begin
        errors++;
        $display("FAIL rand_drop t=%0d: got %b expected %b", t, io_drop, m_drop);
      end
      checks++;
      if (io_level !== m_level) begin
        errors++;
        $display("FAIL rand_level t=%0d: got %b expected %b", t, io_level, m_level);
      end
      checks++;
      if (io_drop_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL rand_drop_cnt t=%0d: got %0d expected %0d", t, io_drop_cnt, m_cnt);
      end
      checks++;
      if (io_pulse === 1'b1 && io_drop === 1'b1) begin
        errors++;
        $display("FAIL rand_pulse_and_drop t=%0d: got both 1 expected at most one", t);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_holdoff();
    test_disable();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
